hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: halt drain, memory-stall wait with timeout,
// taken-branch flush and load-use interlock for a 5-stage pipeline.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic        id_rs_vld,
  input  logic [2:0]  id_rt,
  input  logic        id_rt_vld,
  input  logic        idex_memrd,
  input  logic [2:0]  idex_wreg,
  input  logic        idex_regwr,
  input  logic        ex_br_taken,
  input  logic        exmem_memen,
  input  logic        exmem_halt,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_flush,
  output logic        halted,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_err;
  logic [15:0] r_stall_cnt;

  logic w_memstall;
  logic w_loaduse;
  logic w_halt_win;
  logic w_mem_act;
  logic w_lu_act;

  assign w_memstall = exmem_memen & mem_busy;
  assign w_loaduse  = idex_memrd & idex_regwr &
                      ((id_rs_vld & (id_rs == idex_wreg)) |
                       (id_rt_vld & (id_rt == idex_wreg)));
  // A busy memory keeps MEM_WAIT stalled even if a halt is sitting in EX/MEM;
  // only once the memory is ready do the normal RUN priorities apply.
  assign w_halt_win = exmem_halt & ~((r_state == MEM_WAIT) & w_memstall);

  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;

  // Pipeline control outputs and next state from current state and events.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    w_next      = r_state;
    w_mem_act   = 1'b0;
    w_lu_act    = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_halt_win) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          w_next     = DRAIN;
        end else if (w_memstall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          w_mem_act   = 1'b1;
          w_next      = MEM_WAIT;
        end else if (ex_br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          w_next     = RUN;
        end else if (w_loaduse) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          w_lu_act   = 1'b1;
          w_next     = RUN;
        end else begin
          w_next = RUN;
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        w_next   = HALTED;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        halted   = 1'b1;
        w_next   = HALTED;
      end
    endcase
  end

  // State, memory-wait timer, sticky timeout error and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_mem_act) begin
        if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 8'd1;
        if (r_wait_cnt == '1) r_err <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if ((w_mem_act | w_lu_act) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, branch priority,
// memory stall, halt drain and memory timeout.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_rs;
  logic        id_rs_vld;
  logic [2:0]  id_rt;
  logic        id_rt_vld;
  logic        idex_memrd;
  logic [2:0]  idex_wreg;
  logic        idex_regwr;
  logic        ex_br_taken;
  logic        exmem_memen;
  logic        exmem_halt;
  logic        mem_busy;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_flush;
  logic        halted;
  logic        err;
  logic [15:0] stall_cnt;

  int unsigned n_cmp;
  int unsigned n_bad;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted}
  logic [7:0] w_ctl;
  assign w_ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, halted};

  localparam logic [7:0] C_DEF   = 8'b1101_0100;
  localparam logic [7:0] C_LU    = 8'b0001_1100;
  localparam logic [7:0] C_BR    = 8'b1111_1100;
  localparam logic [7:0] C_MS    = 8'b0000_0010;
  localparam logic [7:0] C_HALT  = 8'b0111_1100;
  localparam logic [7:0] C_DRAIN = 8'b0000_0000;
  localparam logic [7:0] C_HLTD  = 8'b0000_0001;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .idex_memrd(idex_memrd), .idex_wreg(idex_wreg), .idex_regwr(idex_regwr),
    .ex_br_taken(ex_br_taken), .exmem_memen(exmem_memen), .exmem_halt(exmem_halt),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .halted(halted), .err(err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 3'd0; id_rs_vld = 1'b0; id_rt = 3'd0; id_rt_vld = 1'b0;
    idex_memrd = 1'b0; idex_wreg = 3'd0; idex_regwr = 1'b0;
    ex_br_taken = 1'b0; exmem_memen = 1'b0; exmem_halt = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL reset_ctl got %b want %b", w_ctl, C_DEF); end
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wreg = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_LU) begin n_bad++; $display("FAIL lu_rs_ctl got %b want %b", w_ctl, C_LU); end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_rs_cnt got %0d want 1", stall_cnt); end
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL lu_release_ctl got %b want %b", w_ctl, C_DEF); end
    // Rt path alone
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wreg = 3'd5; id_rt = 3'd5; id_rt_vld = 1'b1;
    id_rs = 3'd2; id_rs_vld = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_LU) begin n_bad++; $display("FAIL lu_rt_ctl got %b want %b", w_ctl, C_LU); end
    tick();
    n_cmp++;
    if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL lu_rt_cnt got %0d want 2", stall_cnt); end
    // Matching address but operand not read
    clear_inputs();
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wreg = 3'd4; id_rs = 3'd4; id_rt = 3'd4;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL lu_novld_ctl got %b want %b", w_ctl, C_DEF); end
    // Matching and read, but EX instruction does not write a register
    id_rs_vld = 1'b1; idex_regwr = 1'b0;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL lu_noregwr_ctl got %b want %b", w_ctl, C_DEF); end
    // Not a load
    idex_regwr = 1'b1; idex_memrd = 1'b0;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL lu_noload_ctl got %b want %b", w_ctl, C_DEF); end
    tick();
    n_cmp++;
    if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL lu_nohaz_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    idex_memrd = 1'b1; idex_regwr = 1'b1; idex_wreg = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b1;
    ex_br_taken = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_BR) begin n_bad++; $display("FAIL br_lu_ctl got %b want %b", w_ctl, C_BR); end
    tick();
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL br_lu_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    // mem_busy without memen is not a stall
    mem_busy = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL ms_nomemen_ctl got %b want %b", w_ctl, C_DEF); end
    exmem_memen = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      ex_br_taken = (i == 1);
      #1;
      n_cmp++;
      if (w_ctl !== C_MS) begin n_bad++; $display("FAIL ms_cycle%0d_ctl got %b want %b", i, w_ctl, C_MS); end
      tick();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL ms_done_ctl got %b want %b", w_ctl, C_DEF); end
    n_cmp++;
    if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL ms_cnt got %0d want 3", stall_cnt); end
    // Stall release coinciding with a taken branch: branch acts in that cycle
    exmem_memen = 1'b1; mem_busy = 1'b1;
    tick();
    mem_busy = 1'b0; ex_br_taken = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_BR) begin n_bad++; $display("FAIL ms_exit_br_ctl got %b want %b", w_ctl, C_BR); end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cnt !== 16'd4) begin n_bad++; $display("FAIL ms_exit_cnt got %0d want 4", stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    // Halt outranks a simultaneous memory stall in RUN
    exmem_halt = 1'b1; exmem_memen = 1'b1; mem_busy = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_HALT) begin n_bad++; $display("FAIL halt_ctl got %b want %b", w_ctl, C_HALT); end
    tick();
    clear_inputs();
    ex_br_taken = 1'b1;
    #1;
    n_cmp++;
    if (w_ctl !== C_DRAIN) begin n_bad++; $display("FAIL drain_ctl got %b want %b", w_ctl, C_DRAIN); end
    tick();
    for (int unsigned i = 0; i < 12; i++) begin
      ex_br_taken = i[0];
      exmem_halt  = i[1];
      #1;
      n_cmp++;
      if (w_ctl !== C_HLTD) begin n_bad++; $display("FAIL halted_c%0d_ctl got %b want %b", i, w_ctl, C_HLTD); end
      tick();
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL halt_cnt got %0d want 0", stall_cnt); end
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL halt_rst_ctl got %b want %b", w_ctl, C_DEF); end
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_memen = 1'b1; mem_busy = 1'b1;
    for (int unsigned i = 0; i < 255; i++) tick();
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL to_255_err got %b want 0", err); end
    tick();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL to_256_err got %b want 1", err); end
    n_cmp++;
    if (stall_cnt !== 16'd256) begin n_bad++; $display("FAIL to_256_cnt got %0d want 256", stall_cnt); end
    for (int unsigned i = 0; i < 44; i++) tick();
    n_cmp++;
    if (w_ctl !== C_MS) begin n_bad++; $display("FAIL to_300_ctl got %b want %b", w_ctl, C_MS); end
    n_cmp++;
    if (stall_cnt !== 16'd300) begin n_bad++; $display("FAIL to_300_cnt got %0d want 300", stall_cnt); end
    mem_busy = 1'b0;
    #1;
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL to_release_ctl got %b want %b", w_ctl, C_DEF); end
    tick();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky_err got %b want 1", err); end
    // Reset while a stall is in progress
    mem_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL to_rst_err got %b want 0", err); end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL to_rst_cnt got %0d want 0", stall_cnt); end
    n_cmp++;
    if (w_ctl !== C_DEF) begin n_bad++; $display("FAIL to_rst_ctl got %b want %b", w_ctl, C_DEF); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_mem_stall();
    test_halt();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
